// File: rtl/vend_arbiter.sv
// rtl/vend_arbiter.sv - round-robin scheduler sharing one vending core between stations
module vend_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   coin_valid,
  input  logic [3*N_REQ-1:0] coin,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   abort,
  output logic [2:0]         ret_change,
  output logic [2:0]         core_in,
  output logic               core_clr,
  input  logic               core_out,
  input  logic [2:0]         core_change
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SERVE, FINISH} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur;
  logic [7:0]    cnt;
  logic          vend;
  logic [2:0]    chg;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          cur_req;
  logic          cur_valid;
  logic [2:0]    cur_coin;
  logic [IW-1:0] ptr_next;

  // Round-robin pick: stations at or above ptr win over wrapped ones, lowest index first
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k] && (IW'(k) < ptr)) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(k);
      end
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k] && (IW'(k) >= ptr)) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(k);
      end
    end
  end

  // Select the granted station's request and coin lanes
  always_comb begin
    cur_req   = 1'b0;
    cur_valid = 1'b0;
    cur_coin  = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (cur == IW'(k)) begin
        cur_req   = req[k];
        cur_valid = coin_valid[k];
        cur_coin  = coin[3*k +: 3];
      end
    end
  end

  assign ptr_next = (cur == IW'(N_REQ - 1)) ? '0 : cur + IW'(1);

  // Session FSM with registered outputs; done/abort/core_clr are single-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur        <= '0;
      cnt        <= 8'd0;
      vend       <= 1'b0;
      chg        <= 3'd0;
      grant      <= '0;
      done       <= '0;
      abort      <= '0;
      ret_change <= 3'd0;
      core_in    <= 3'd0;
      core_clr   <= 1'b0;
    end else begin
      done       <= '0;
      abort      <= '0;
      core_clr   <= 1'b0;
      ret_change <= 3'd0;
      core_in    <= 3'd0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            cur   <= pick_idx;
            grant <= ONE << pick_idx;
            cnt   <= 8'd0;
            vend  <= 1'b0;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (core_out) begin
            // a coin arriving with the vend is dropped on purpose
            chg   <= core_change;
            vend  <= 1'b1;
            state <= FINISH;
          end else if (!cur_req) begin
            vend  <= 1'b0;
            state <= FINISH;
          end else if (cnt == 8'(TIMEOUT)) begin
            vend  <= 1'b0;
            state <= FINISH;
          end else if (cur_valid && (cur_coin != 3'd0)) begin
            core_in <= cur_coin;
            cnt     <= 8'd0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        FINISH: begin
          grant <= '0;
          if (vend) begin
            done       <= ONE << cur;
            ret_change <= chg;
          end else begin
            abort    <= ONE << cur;
            core_clr <= 1'b1;
          end
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
